// File: rtl/count_capture.sv
// Coherent snapshot capture for a skewed/ripple counter, with TC wrap extension and VALID/ACK delivery.
// Optional sticky overrun flag built only when COUNT_CAPTURE_OVR_EN is defined.
module count_capture #(
  parameter int CNT_W   = 16,
  parameter int WRAP_W  = 8,
  parameter int TIMEOUT = 15,
  parameter int AUTO_TC = 1
) (
  input  logic              CLK,
  input  logic              CLR_N,
  input  logic [CNT_W-1:0]  CNT_Q,
  input  logic              CNT_TC,
  input  logic              REQ,
  input  logic              ACK,
  output logic              VALID,
  output logic [CNT_W-1:0]  SNAP_Q,
  output logic [WRAP_W-1:0] SNAP_WRAP,
  output logic              ERR,
  output logic              OVR
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
  localparam logic       AUTO_EN   = (AUTO_TC != 0);

  logic [CNT_W-1:0]  s1_cnt_q, s2_cnt_q;
  logic              s1_tc_q, s2_tc_q;
  logic [WRAP_W-1:0] wrap_q, wrap_d;

  state_t            state_q;
  logic [7:0]        timer_q;
  logic [7:0]        timer_inc;
  logic              pend_q;
  logic              valid_q;
  logic              err_q;
  logic [CNT_W-1:0]  snap_q_q;
  logic [WRAP_W-1:0] snap_wrap_q;

  logic [CNT_W-1:0]  s2_cnt_inc;
  logic              coherent;
  logic              tc_edge;
  logic              trigger;
  logic              timed_out;

  // The low ripple bits settle late, so two back-to-back samples must agree
  // (held) or differ by exactly one count (counting, including the wrap).
  assign s2_cnt_inc = s2_cnt_q + CNT_W'(1);
  assign coherent   = (s1_cnt_q == s2_cnt_q) || (s1_cnt_q == s2_cnt_inc);
  assign tc_edge    = s1_tc_q & ~s2_tc_q;
  assign wrap_d     = wrap_q + WRAP_W'(tc_edge);
  assign trigger    = REQ | (AUTO_EN & tc_edge);
  assign timer_inc  = timer_q + 8'd1;
  assign timed_out  = (timer_inc >= TIMEOUT_C);

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      s1_cnt_q <= '0;
      s1_tc_q  <= 1'b0;
      s2_cnt_q <= '0;
      s2_tc_q  <= 1'b0;
      wrap_q   <= '0;
    end else begin
      s1_cnt_q <= CNT_Q;
      s1_tc_q  <= CNT_TC;
      s2_cnt_q <= s1_cnt_q;
      s2_tc_q  <= s1_tc_q;
      wrap_q   <= wrap_d;
    end
  end

`ifdef COUNT_CAPTURE_OVR_EN
  logic ovr_q;
`endif

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      pend_q      <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      snap_q_q    <= '0;
      snap_wrap_q <= '0;
`ifdef COUNT_CAPTURE_OVR_EN
      ovr_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (trigger) begin
            state_q <= ARMED;
            timer_q <= '0;
          end
        end
        ARMED: begin
          // Snapshot takes the wrap value including any edge seen this cycle.
          if (coherent) begin
            snap_q_q    <= s1_cnt_q;
            snap_wrap_q <= wrap_d;
            err_q       <= 1'b0;
            valid_q     <= 1'b1;
            state_q     <= HOLD;
          end else if (timed_out) begin
            snap_q_q    <= s1_cnt_q;
            snap_wrap_q <= wrap_d;
            err_q       <= 1'b1;
            valid_q     <= 1'b1;
            state_q     <= HOLD;
            timer_q     <= timer_inc;
`ifdef COUNT_CAPTURE_OVR_EN
            ovr_q       <= 1'b1;
`endif
          end else begin
            timer_q <= timer_inc;
          end
        end
        HOLD: begin
`ifdef COUNT_CAPTURE_OVR_EN
          if (trigger && pend_q) begin
            ovr_q <= 1'b1;
          end
`endif
          if (ACK) begin
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
            timer_q <= '0;
            state_q <= (pend_q || trigger) ? ARMED : IDLE;
          end else if (trigger) begin
            pend_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          pend_q  <= 1'b0;
        end
      endcase
    end
  end

  assign VALID     = valid_q;
  assign SNAP_Q    = snap_q_q;
  assign SNAP_WRAP = snap_wrap_q;
  assign ERR       = err_q;

`ifdef COUNT_CAPTURE_OVR_EN
  assign OVR = ovr_q;
`else
  assign OVR = 1'b0;
`endif

endmodule

// File: tb/tb_count_capture.sv
// Randomized plus directed bench for count_capture against a behavioural snapshot model.
// The model honours COUNT_CAPTURE_OVR_EN the same way the build does.
module tb_count_capture;

  localparam int TIMEOUT = 15;

  logic        CLK;
  logic        CLR_N;
  logic [15:0] CNT_Q;
  logic        CNT_TC;
  logic        REQ;
  logic        ACK;
  logic        VALID, ERR, OVR;
  logic [15:0] SNAP_Q;
  logic [7:0]  SNAP_WRAP;
  logic        VALID_B, ERR_B, OVR_B;
  logic [15:0] SNAP_Q_B;
  logic [7:0]  SNAP_WRAP_B;

  count_capture #(.CNT_W(16), .WRAP_W(8), .TIMEOUT(TIMEOUT), .AUTO_TC(1)) dut (
    .CLK(CLK), .CLR_N(CLR_N), .CNT_Q(CNT_Q), .CNT_TC(CNT_TC), .REQ(REQ), .ACK(ACK),
    .VALID(VALID), .SNAP_Q(SNAP_Q), .SNAP_WRAP(SNAP_WRAP), .ERR(ERR), .OVR(OVR)
  );

  count_capture #(.CNT_W(16), .WRAP_W(8), .TIMEOUT(TIMEOUT), .AUTO_TC(0)) dut_b (
    .CLK(CLK), .CLR_N(CLR_N), .CNT_Q(CNT_Q), .CNT_TC(CNT_TC), .REQ(REQ), .ACK(ACK),
    .VALID(VALID_B), .SNAP_Q(SNAP_Q_B), .SNAP_WRAP(SNAP_WRAP_B), .ERR(ERR_B), .OVR(OVR_B)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: recent counter samples, total TC edges, handshake phase.
  int unsigned hist_cnt[$];
  bit          hist_tc[$];
  int          m_phase;   // 0 waiting for trigger, 1 looking for coherent samples, 2 presenting
  int          m_wait;
  bit          m_pend;
  int          m_edges;
  bit          m_valid;
  int          m_snap;
  int          m_swrap;
  bit          m_err;
  bit          m_ovr;

  task automatic model_reset();
    hist_cnt = {0, 0};
    hist_tc  = {0, 0};
    m_phase = 0; m_wait = 0; m_pend = 0; m_edges = 0;
    m_valid = 0; m_snap = 0; m_swrap = 0; m_err = 0; m_ovr = 0;
  endtask

  task automatic model_capture(input int cnt, input int wrap, input bit bad);
    m_snap  = cnt;
    m_swrap = wrap;
    m_err   = bad;
    m_valid = 1;
    m_phase = 2;
`ifdef COUNT_CAPTURE_OVR_EN
    if (bad) m_ovr = 1;
`endif
  endtask

  task automatic model_clock(input int cnt, input bit tc, input bit req, input bit ack);
    int newest, older, diff, wrap_after;
    bit edge_seen, trig, coh;
    newest     = int'(hist_cnt[0]);
    older      = int'(hist_cnt[1]);
    diff       = (newest - older) & 32'hFFFF;
    coh        = (diff == 0) || (diff == 1);
    edge_seen  = hist_tc[0] && !hist_tc[1];
    wrap_after = (m_edges + int'(edge_seen)) % 256;
    trig       = req || edge_seen;
    case (m_phase)
      0: if (trig) begin m_phase = 1; m_wait = 0; end
      1: begin
        if (coh) model_capture(newest, wrap_after, 0);
        else begin
          m_wait++;
          if (m_wait >= TIMEOUT) model_capture(newest, wrap_after, 1);
        end
      end
      default: begin
`ifdef COUNT_CAPTURE_OVR_EN
        if (trig && m_pend) m_ovr = 1;
`endif
        if (ack) begin
          m_valid = 0;
          m_phase = (m_pend || trig) ? 1 : 0;
          m_wait  = 0;
          m_pend  = 0;
        end else if (trig) m_pend = 1;
      end
    endcase
    m_edges = wrap_after;
    hist_cnt.push_front(cnt[15:0]); void'(hist_cnt.pop_back());
    hist_tc.push_front(tc);         void'(hist_tc.pop_back());
  endtask

  task automatic compare_all();
    chk("valid", VALID, m_valid);
    chk("snap_q", SNAP_Q, m_snap);
    chk("snap_wrap", SNAP_WRAP, m_swrap);
    chk("err", ERR, m_err);
    chk("ovr", OVR, m_ovr);
  endtask

  // Called at a falling edge; drives, lets one rising edge pass, checks.
  task automatic step(input int cnt, input bit tc, input bit req, input bit ack);
    CNT_Q  = cnt[15:0];
    CNT_TC = tc;
    REQ    = req;
    ACK    = ack;
    model_clock(cnt, tc, req, ack);
    @(posedge CLK);
    @(negedge CLK);
    compare_all();
  endtask

  task automatic async_reset();
    #2 CLR_N = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge CLK);
    CLR_N = 1'b1;
  endtask

  bit exp_ovr;
  bit in_set;
  int cur;

  initial begin
`ifdef COUNT_CAPTURE_OVR_EN
    exp_ovr = 1;
`else
    exp_ovr = 0;
`endif
    CLR_N = 1'b0; CNT_Q = '0; CNT_TC = 1'b0; REQ = 1'b0; ACK = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    compare_all();
    CLR_N = 1'b1;

    // Held counter, single request: VALID two cycles after REQ.
    repeat (5) step(16'h1234, 0, 0, 0);
    step(16'h1234, 0, 1, 0);
    chk("held_valid_n1", VALID, 0);
    step(16'h1234, 0, 0, 0);
    chk("held_valid_n2", VALID, 1);
    chk("held_snap", SNAP_Q, 16'h1234);
    chk("held_wrap", SNAP_WRAP, 0);
    chk("held_err", ERR, 0);
    step(16'h1234, 0, 0, 0);
    step(16'h1234, 0, 0, 1);
    chk("held_ack_valid", VALID, 0);
    repeat (3) step(16'h1234, 0, 0, 0);
    chk("held_idle_valid", VALID, 0);

    // Free-running through the wrap; TC edge auto-triggers.
    async_reset();
    repeat (3) step(16'hFFFD, 0, 0, 0);
    cur = 16'hFFFD;
    for (int i = 0; i < 6; i++) begin
      cur = (cur + 1) & 16'hFFFF;
      step(cur, cur == 16'hFFFF, 0, 0);
    end
    chk("wrap_valid", VALID, 1);
    chk("wrap_swrap", SNAP_WRAP, 1);
    chk("wrap_err", ERR, 0);
    in_set = (SNAP_Q == 16'hFFFF) || (SNAP_Q == 16'h0000) || (SNAP_Q == 16'h0001);
    chk("wrap_snap_range", in_set, 1);
    step(cur, 0, 0, 1);

    // Incoherent toggling forces a timeout capture.
    async_reset();
    step(16'h8000, 0, 1, 0);
    for (int i = 0; i < 19; i++) step((i % 2 == 0) ? 16'h0000 : 16'h8000, 0, 0, 0);
    chk("tmo_valid", VALID, 1);
    chk("tmo_err", ERR, 1);
    chk("tmo_ovr", OVR, exp_ovr);
    step(16'h0100, 0, 0, 1);
    repeat (3) step(16'h0100, 0, 0, 0);

    // Two requests while presenting: pending re-arm after ACK.
    async_reset();
    repeat (3) step(16'h0055, 0, 0, 0);
    step(16'h0055, 0, 1, 0);
    step(16'h0055, 0, 0, 0);
    step(16'h0055, 0, 1, 0);
    step(16'h0055, 0, 0, 0);
    step(16'h0055, 0, 1, 0);
    chk("pend_ovr", OVR, exp_ovr);
    step(16'h0055, 0, 0, 1);
    chk("pend_ack_valid", VALID, 0);
    step(16'h0055, 0, 0, 0);
    chk("pend_second_valid", VALID, 1);
    chk("pend_ovr_sticky", OVR, exp_ovr);
    step(16'h0055, 0, 0, 1);

    // 256 TC edges; the instance without auto-trigger must stay quiet.
    async_reset();
    for (int i = 0; i < 256; i++) begin
      step(16'h0042, 1, 0, 1);
      chk("noauto_valid", VALID_B, 0);
      step(16'h0042, 0, 0, 1);
      chk("noauto_valid", VALID_B, 0);
    end
    repeat (2) step(16'h0042, 0, 0, 1);
    step(16'h0042, 0, 1, 0);
    step(16'h0042, 0, 0, 0);
    chk("noauto_cap_valid", VALID_B, 1);
    chk("noauto_cap_wrap", SNAP_WRAP_B, 0);
    chk("noauto_cap_snap", SNAP_Q_B, 16'h0042);
    chk("noauto_cap_err", ERR_B, 0);
    chk("noauto_cap_ovr", OVR_B, 0);
    step(16'h0042, 0, 0, 1);

    // Reset while presenting, then a normal capture.
    repeat (2) step(16'h0999, 0, 0, 0);
    step(16'h0999, 0, 1, 0);
    step(16'h0999, 0, 0, 0);
    chk("rst_pre_valid", VALID, 1);
    async_reset();
    chk("rst_valid", VALID, 0);
    chk("rst_snap", SNAP_Q, 0);
    step(16'h0777, 0, 1, 0);
    repeat (3) step(16'h0777, 0, 0, 0);
    chk("rst_recap_valid", VALID, 1);
    chk("rst_recap_snap", SNAP_Q, 16'h0777);
    step(16'h0777, 0, 0, 1);

    // Random traffic: counting, holding and glitching samples.
    cur = $urandom_range(0, 65535);
    for (int i = 0; i < 2500; i++) begin
      int r;
      bit tc;
      r = $urandom_range(0, 9);
      if (r <= 5) cur = (cur + 1) & 16'hFFFF;
      else if (r >= 8) cur = $urandom_range(0, 65535);
      tc = (cur == 16'hFFFF) || ($urandom_range(0, 19) == 0);
      step(cur, tc, $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 399) == 0) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
